// File: rtl/axi_slv_mem.sv
// AXI slave responder backed by a word-addressed memory; independent write (AW/W/B) and read (AR/R) FSMs.
// Optional macro AXI_SLV_MEM_WID_CHECK_EN enables per-beat WID vs AWID checking on the write path.
module axi_slv_mem #(
    parameter int unsigned D_ID_WIDTH   = 4,
    parameter int unsigned D_ADDR_WIDTH = 32,
    parameter int unsigned D_DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH    = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [D_ID_WIDTH-1:0]     AWID,
    input  logic [D_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [D_ID_WIDTH-1:0]     WID,
    input  logic [D_DATA_WIDTH-1:0]   WDATA,
    input  logic [D_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [D_ID_WIDTH-1:0]     BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [D_ID_WIDTH-1:0]     ARID,
    input  logic [D_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic [2:0]                ARPROT,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [D_ID_WIDTH-1:0]     RID,
    output logic [D_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam int unsigned NB  = D_DATA_WIDTH / 8;
    localparam int unsigned LSB = $clog2(NB);
    localparam int unsigned IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] MAX_SIZE = 3'(LSB);
    localparam logic [D_ADDR_WIDTH-1:0] DEPTH_A = D_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic {RIdle, RData} rstate_e;

    logic [D_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [D_ADDR_WIDTH-1:0] next_addr(input logic [D_ADDR_WIDTH-1:0] addr,
                                                          input logic [7:0] len,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
        logic [D_ADDR_WIDTH-1:0] bytes, aligned, span, na;
        bytes   = D_ADDR_WIDTH'(1) << size;
        aligned = addr & ~(bytes - D_ADDR_WIDTH'(1));
        span    = (D_ADDR_WIDTH'(len) + D_ADDR_WIDTH'(1)) << size;
        case (burst)
            BURST_FIXED: na = addr;
            BURST_INCR:  na = aligned + bytes;
            BURST_WRAP:  na = (addr & ~(span - D_ADDR_WIDTH'(1))) |
                              ((aligned + bytes) & (span - D_ADDR_WIDTH'(1)));
            default:     na = addr;
        endcase
        return na;
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (burst == 2'b11) || bad_wrap || (size > MAX_SIZE);
    endfunction

    // ---------------- write path ----------------
    wstate_e                 w_q, w_d;
    logic                    awready_q;
    logic [D_ID_WIDTH-1:0]   wid_q, wid_d;
    logic [D_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]              wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]              wsize_q, wsize_d;
    logic [1:0]              wburst_q, wburst_d;
    logic                    werr_q, werr_d;
    logic                    mem_we, wbeat_err, wid_err;
    logic [D_ADDR_WIDTH-1:0] waddr_word;

    assign waddr_word = waddr_q >> LSB;

`ifdef AXI_SLV_MEM_WID_CHECK_EN
    assign wid_err = (WID != wid_q);
`else
    assign wid_err = 1'b0;
`endif

    assign wbeat_err = burst_err(wlen_q, wsize_q, wburst_q) || (waddr_word >= DEPTH_A) ||
                       (WLAST != (wcnt_q == wlen_q)) || wid_err;

    always_comb begin
        w_d      = w_q;
        wid_d    = wid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        wcnt_d   = wcnt_q;
        mem_we   = 1'b0;
        case (w_q)
            WIdle: begin
                if (AWVALID && awready_q) begin
                    wid_d    = AWID;
                    waddr_d  = AWADDR;
                    wlen_d   = AWLEN;
                    wsize_d  = AWSIZE;
                    wburst_d = AWBURST;
                    werr_d   = 1'b0;
                    wcnt_d   = 8'd0;
                    w_d      = WData;
                end
            end
            WData: begin
                if (WVALID) begin
                    mem_we  = !wbeat_err;
                    werr_d  = werr_q | wbeat_err;
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q) w_d = WResp;
                end
            end
            WResp: begin
                if (BREADY) w_d = WIdle;
            end
            default: w_d = WIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_q       <= WIdle;
            awready_q <= 1'b0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            w_q       <= w_d;
            awready_q <= (w_d == WIdle);
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Memory is deliberately not reset; writes during reset are dropped.
    always_ff @(posedge ACLK) begin
        if (mem_we && !ARESET) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (WSTRB[b]) mem[waddr_word[IW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = (w_q == WData);
    assign BVALID  = (w_q == WResp);
    assign BID     = wid_q;
    assign BRESP   = (w_q == WResp && werr_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read path ----------------
    rstate_e                 r_q, r_d;
    logic                    arready_q;
    logic [D_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [D_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]              rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]              rsize_q, rsize_d;
    logic [1:0]              rburst_q, rburst_d;
    logic [D_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;

    // The beat being loaded comes from AR in idle, otherwise from the captured burst.
    logic                    ridle;
    logic [D_ADDR_WIDTH-1:0] rsel_addr, rload_word;
    logic [7:0]              rsel_len;
    logic [2:0]              rsel_size;
    logic [1:0]              rsel_burst;
    logic                    rload_err;
    logic [D_DATA_WIDTH-1:0] rload_data;

    assign ridle      = (r_q == RIdle);
    assign rsel_addr  = ridle ? ARADDR  : raddr_q;
    assign rsel_len   = ridle ? ARLEN   : rlen_q;
    assign rsel_size  = ridle ? ARSIZE  : rsize_q;
    assign rsel_burst = ridle ? ARBURST : rburst_q;
    assign rload_word = rsel_addr >> LSB;
    assign rload_err  = burst_err(rsel_len, rsel_size, rsel_burst) || (rload_word >= DEPTH_A);
    assign rload_data = mem[rload_word[IW-1:0]];

    always_comb begin
        r_d      = r_q;
        rid_d    = rid_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rsize_d  = rsize_q;
        rburst_d = rburst_q;
        rcnt_d   = rcnt_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        case (r_q)
            RIdle: begin
                if (ARVALID && arready_q) begin
                    rid_d    = ARID;
                    rlen_d   = ARLEN;
                    rsize_d  = ARSIZE;
                    rburst_d = ARBURST;
                    rcnt_d   = 8'd0;
                    raddr_d  = next_addr(ARADDR, ARLEN, ARSIZE, ARBURST);
                    rdata_d  = rload_err ? '0 : rload_data;
                    rresp_d  = rload_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d  = (ARLEN == 8'd0);
                    r_d      = RData;
                end
            end
            RData: begin
                if (RREADY) begin
                    if (rlast_q) begin
                        r_d = RIdle;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        rdata_d = rload_err ? '0 : rload_data;
                        rresp_d = rload_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_d = RIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_q       <= RIdle;
            arready_q <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            r_q       <= r_d;
            arready_q <= (r_d == RIdle);
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = (r_q == RData);
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

    logic unused_ok;
`ifdef AXI_SLV_MEM_WID_CHECK_EN
    assign unused_ok = ^{AWPROT, ARPROT};
`else
    assign unused_ok = ^{AWPROT, ARPROT, WID};
`endif

endmodule
